// File: rtl/bit_deframer.sv
// Serial bit-stream deframer: hunts for a sync byte, then collects FRAME_LEN payload
// bytes MSB first into a small first-word-fall-through FIFO with a valid/ready output.
module bit_deframer #(
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         FRAME_LEN  = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       overflow
);

    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam int         CNT_W     = PTR_W + 1;
    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

    state_t     state_reg, state_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] byte_cnt_reg, byte_cnt_next;
    logic [7:0] shift_val;
    logic       push_req;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop, push_ok, push_drop;

    // State and deframing datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_HUNT;
            shreg_reg    <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        push_req      = 1'b0;
        shift_val     = {shreg_reg[6:0], bit_in};
        if (bit_valid) begin
            shreg_next = shift_val;
            case (state_reg)
                ST_HUNT: begin
                    if (shift_val == SYNC_WORD) begin
                        state_next    = ST_LOCKED;
                        bit_cnt_next  = 3'd0;
                        byte_cnt_next = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        push_req      = 1'b1;
                        byte_cnt_next = byte_cnt_reg + 8'd1;
                        // Last byte of the frame: flush the window so the next sync needs 8 fresh bits
                        if (byte_cnt_reg == LAST_BYTE) begin
                            state_next    = ST_HUNT;
                            shreg_next    = 8'h00;
                            byte_cnt_next = 8'd0;
                        end
                    end
                end
                default: state_next = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        locked = (state_reg == ST_LOCKED);
    end

    // A push into a full FIFO is still accepted when the head leaves on the same edge
    assign pop       = byte_valid & byte_ready;
    assign push_ok   = push_req & ((count_reg != CNT_W'(FIFO_DEPTH)) | pop);
    assign push_drop = push_req & ~push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= shift_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Empty FIFO presents zero so reset forces byte_out low without resetting storage
    assign byte_valid = (count_reg != '0);
    assign byte_out   = byte_valid ? mem[rd_ptr_reg] : 8'h00;

endmodule

// File: tb/tb_bit_deframer.sv
// Directed bench for bit_deframer (FRAME_LEN=2, FIFO_DEPTH=4): sync hunt, framing,
// gapped input, backpressure/overflow, push-with-pop at full, and mid-frame reset.
module tb_bit_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       locked;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sync_v = 8'hA5;
    logic [7:0] tmp_v;

    always #5 clk = ~clk;

    bit_deframer #(
        .SYNC_WORD (8'hA5),
        .FRAME_LEN (2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .locked    (locked),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One valid bit per call; with gap=1 an idle (bit_valid=0) cycle precedes it
    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            bit_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], gap);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expects the head of the FIFO, then lets one edge pass (pops when byte_ready=1)
    task automatic expect_head(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 8'(byte_valid), 8'd1);
        check(tag, byte_out, exp);
        idle(1);
    endtask

    initial begin
        // Reset
        #3 rst = 1'b0;
        #1;
        check("rst_valid", 8'(byte_valid), 8'd0);
        check("rst_locked", 8'(locked), 8'd0);
        check("rst_overflow", 8'(overflow), 8'd0);
        check("rst_byte_out", byte_out, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        byte_ready = 1'b1;

        // Sync and frame capture: A5 3C C3
        for (int i = 7; i >= 1; i--) send_bit(sync_v[i], 1'b0);
        check("t1_locked_7bits", 8'(locked), 8'd0);
        send_bit(sync_v[0], 1'b0);
        check("t1_locked_8bits", 8'(locked), 8'd1);
        send_byte(8'h3C, 1'b0);
        check("t1_b0_valid", 8'(byte_valid), 8'd1);
        check("t1_b0", byte_out, 8'h3C);
        tmp_v = 8'hC3;
        send_bit(tmp_v[7], 1'b0);
        check("t1_b0_one_cycle", 8'(byte_valid), 8'd0);
        for (int i = 6; i >= 0; i--) send_bit(tmp_v[i], 1'b0);
        check("t1_b1_valid", 8'(byte_valid), 8'd1);
        check("t1_b1", byte_out, 8'hC3);
        check("t1_unlocked", 8'(locked), 8'd0);
        idle(1);
        check("t1_b1_one_cycle", 8'(byte_valid), 8'd0);

        // Hunt with near-miss prefix A4, then A5 01 02
        send_byte(8'hA4, 1'b0);
        check("t2_prefix_locked", 8'(locked), 8'd0);
        check("t2_prefix_valid", 8'(byte_valid), 8'd0);
        for (int i = 7; i >= 1; i--) send_bit(sync_v[i], 1'b0);
        check("t2_locked_7bits", 8'(locked), 8'd0);
        send_bit(sync_v[0], 1'b0);
        check("t2_locked", 8'(locked), 8'd1);
        check("t2_no_prefix_byte", 8'(byte_valid), 8'd0);
        send_byte(8'h01, 1'b0);
        check("t2_b0", byte_out, 8'h01);
        send_byte(8'h02, 1'b0);
        check("t2_b1", byte_out, 8'h02);
        check("t2_unlocked", 8'(locked), 8'd0);
        idle(1);

        // Gapped input: A5 F0 0F with an idle cycle before every bit
        send_byte(8'hA5, 1'b1);
        check("t3_locked", 8'(locked), 8'd1);
        send_byte(8'hF0, 1'b1);
        check("t3_b0_valid", 8'(byte_valid), 8'd1);
        check("t3_b0", byte_out, 8'hF0);
        send_byte(8'h0F, 1'b1);
        check("t3_b1", byte_out, 8'h0F);
        check("t3_unlocked", 8'(locked), 8'd0);
        idle(1);

        // Fill to 4 entries, then pop exactly on the edge that pushes the 5th
        byte_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h21, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        check("t4_full_head", byte_out, 8'h20);
        send_byte(8'hA5, 1'b0);
        tmp_v = 8'h24;
        for (int i = 7; i >= 1; i--) send_bit(tmp_v[i], 1'b0);
        byte_ready = 1'b1;
        send_bit(tmp_v[0], 1'b0);
        byte_ready = 1'b0;
        check("t4_no_overflow", 8'(overflow), 8'd0);
        check("t4_head_after_pop", byte_out, 8'h21);
        idle(2);
        check("t4_still_full_head", byte_out, 8'h21);
        byte_ready = 1'b1;
        expect_head("t4_d0", 8'h21);
        expect_head("t4_d1", 8'h22);
        expect_head("t4_d2", 8'h23);
        expect_head("t4_d3", 8'h24);
        check("t4_empty", 8'(byte_valid), 8'd0);
        send_byte(8'h25, 1'b0);
        check("t4_tail", byte_out, 8'h25);
        check("t4_unlocked", 8'(locked), 8'd0);
        idle(1);
        byte_ready = 1'b0;

        // Backpressure: 10..13 stored, 14 and 15 dropped
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h13, 1'b0);
        check("t5_pre_overflow", 8'(overflow), 8'd0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h14, 1'b0);
        check("t5_overflow", 8'(overflow), 8'd1);
        check("t5_head", byte_out, 8'h10);
        send_byte(8'h15, 1'b0);
        check("t5_unlocked", 8'(locked), 8'd0);
        byte_ready = 1'b1;
        expect_head("t5_d0", 8'h10);
        expect_head("t5_d1", 8'h11);
        expect_head("t5_d2", 8'h12);
        expect_head("t5_d3", 8'h13);
        check("t5_empty", 8'(byte_valid), 8'd0);
        check("t5_sticky", 8'(overflow), 8'd1);

        // Reset mid-frame with 2 bytes queued and overflow set
        byte_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) send_bit((i >= 2) ? 1'b1 : 1'b0, 1'b0);
        check("t6_pre_valid", 8'(byte_valid), 8'd1);
        check("t6_pre_locked", 8'(locked), 8'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", 8'(byte_valid), 8'd0);
        check("t6_rst_locked", 8'(locked), 8'd0);
        check("t6_rst_overflow", 8'(overflow), 8'd0);
        check("t6_rst_byte_out", byte_out, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        byte_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h33, 1'b0);
        check("t6_no_byte", 8'(byte_valid), 8'd0);
        check("t6_hunting", 8'(locked), 8'd0);
        send_byte(8'hA5, 1'b0);
        check("t6_relock", 8'(locked), 8'd1);
        send_byte(8'h44, 1'b0);
        check("t6_b0", byte_out, 8'h44);
        send_byte(8'h45, 1'b0);
        check("t6_b1", byte_out, 8'h45);
        check("t6_unlocked", 8'(locked), 8'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
